// File: rtl/rsa_job_arbiter_pkg.sv
// Shared types for the RSA job arbiter: operand width, key type and arbiter states.
package rsa_job_arbiter_pkg;

    localparam int MOD_WIDTH = 32;

    typedef logic [MOD_WIDTH-1:0] KeyType;

    typedef enum logic [1:0] {
        ARB_IDLE  = 2'd0,
        ARB_ISSUE = 2'd1,
        ARB_WAIT  = 2'd2
    } ArbState_t;

endpackage

// File: rtl/rsa_job_arbiter_picker.sv
// Combinational round-robin picker: first set request at or after ptr, with wrap-around.
module rr_priority_picker #(
    parameter int N  = 4,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] grant_idx,
    output logic          any
);

    localparam logic [2*N-1:0] ONE_2N = {{(2*N-1){1'b0}}, 1'b1};

    logic [2*N-1:0] mask_s;
    logic [2*N-1:0] masked_s;
    logic [2*N-1:0] first_s;

    // Doubling the request vector turns the wrapped search into a plain lowest-set-bit search
    always_comb begin
        mask_s    = ~((ONE_2N << ptr) - ONE_2N);
        masked_s  = {req, req} & mask_s;
        first_s   = masked_s & (~masked_s + ONE_2N);
        grant     = first_s[N-1:0] | first_s[2*N-1:N];
        any       = |req;
        grant_idx = {IW{1'b0}};
        for (int i = 0; i < N; i++) begin
            if (grant[i]) begin
                grant_idx = IW'(i);
            end else begin
                grant_idx = grant_idx;
            end
        end
    end

endmodule

// File: rtl/rsa_job_arbiter.sv
// Round-robin sharing of one RSA exponentiation core among N_REQ requesters,
// one job in flight, with result routing and per-job latency measurement.
module rsa_job_arbiter
    import rsa_job_arbiter_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int ID_W  = $clog2(N_REQ),
    parameter int CNT_W = 32
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [N_REQ-1:0]                req_valid,
    output logic [N_REQ-1:0]                req_ready,
    input  logic [N_REQ-1:0][MOD_WIDTH-1:0] req_msg,
    input  logic [N_REQ-1:0][MOD_WIDTH-1:0] req_key,
    input  logic [N_REQ-1:0][MOD_WIDTH-1:0] req_modulus,
    output logic [N_REQ-1:0]                rsp_valid,
    input  logic [N_REQ-1:0]                rsp_ready,
    output logic [MOD_WIDTH-1:0]            rsp_crypto,
    output logic                            core_i_valid,
    input  logic                            core_i_ready,
    output logic [MOD_WIDTH-1:0]            core_msg,
    output logic [MOD_WIDTH-1:0]            core_key,
    output logic [MOD_WIDTH-1:0]            core_modulus,
    input  logic                            core_o_valid,
    output logic                            core_o_ready,
    input  logic [MOD_WIDTH-1:0]            core_crypto,
    output logic [ID_W-1:0]                 owner_id,
    output logic                            busy,
    output logic [CNT_W-1:0]                last_latency
);

    ArbState_t           state_r;
    logic [ID_W-1:0]     rr_ptr_r;
    logic [ID_W-1:0]     owner_id_r;
    KeyType              msg_r;
    KeyType              key_r;
    KeyType              modulus_r;
    logic                core_i_valid_r;
    logic [CNT_W-1:0]    cnt_r;
    logic [CNT_W-1:0]    last_latency_r;

    logic [N_REQ-1:0]    grant_s;
    logic [ID_W-1:0]     grant_idx_s;
    logic                any_s;
    logic [ID_W-1:0]     next_ptr_s;
    logic [N_REQ-1:0]    owner_mask_s;
    logic                in_wait_s;
    logic                core_o_ready_s;
    logic [CNT_W-1:0]    cnt_sat_s;

    rr_priority_picker #(
        .N  (N_REQ),
        .IW (ID_W)
    ) u_picker (
        .req       (req_valid),
        .ptr       (rr_ptr_r),
        .grant     (grant_s),
        .grant_idx (grant_idx_s),
        .any       (any_s)
    );

    // Handshake steering: grants only in IDLE, result path only to the owner while waiting
    always_comb begin
        in_wait_s      = (state_r == ARB_WAIT);
        owner_mask_s   = {{(N_REQ-1){1'b0}}, 1'b1} << owner_id_r;
        core_o_ready_s = in_wait_s & rsp_ready[owner_id_r];
        if (state_r == ARB_IDLE) begin
            req_ready = grant_s;
        end else begin
            req_ready = {N_REQ{1'b0}};
        end
        if (in_wait_s && core_o_valid) begin
            rsp_valid = owner_mask_s;
        end else begin
            rsp_valid = {N_REQ{1'b0}};
        end
        if (grant_idx_s == ID_W'(N_REQ-1)) begin
            next_ptr_s = {ID_W{1'b0}};
        end else begin
            next_ptr_s = grant_idx_s + ID_W'(1);
        end
        if (cnt_r == {CNT_W{1'b1}}) begin
            cnt_sat_s = cnt_r;
        end else begin
            cnt_sat_s = cnt_r + CNT_W'(1);
        end
    end

    // Arbiter FSM with payload capture and issue-to-result latency counter
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r        <= ARB_IDLE;
            rr_ptr_r       <= {ID_W{1'b0}};
            owner_id_r     <= {ID_W{1'b0}};
            msg_r          <= {MOD_WIDTH{1'b0}};
            key_r          <= {MOD_WIDTH{1'b0}};
            modulus_r      <= {MOD_WIDTH{1'b0}};
            core_i_valid_r <= 1'b0;
            cnt_r          <= {CNT_W{1'b0}};
            last_latency_r <= {CNT_W{1'b0}};
        end else begin
            case (state_r)
                ARB_IDLE: begin
                    if (any_s) begin
                        msg_r          <= req_msg[grant_idx_s];
                        key_r          <= req_key[grant_idx_s];
                        modulus_r      <= req_modulus[grant_idx_s];
                        owner_id_r     <= grant_idx_s;
                        rr_ptr_r       <= next_ptr_s;
                        cnt_r          <= {CNT_W{1'b0}};
                        core_i_valid_r <= 1'b1;
                        state_r        <= ARB_ISSUE;
                    end
                end
                ARB_ISSUE: begin
                    if (core_i_ready) begin
                        core_i_valid_r <= 1'b0;
                        cnt_r          <= CNT_W'(1);
                        state_r        <= ARB_WAIT;
                    end
                end
                ARB_WAIT: begin
                    cnt_r <= cnt_sat_s;
                    if (core_o_valid && core_o_ready_s) begin
                        last_latency_r <= cnt_r;
                        state_r        <= ARB_IDLE;
                    end
                end
                default: begin
                    core_i_valid_r <= 1'b0;
                    state_r        <= ARB_IDLE;
                end
            endcase
        end
    end

    assign core_i_valid = core_i_valid_r;
    assign core_msg     = msg_r;
    assign core_key     = key_r;
    assign core_modulus = modulus_r;
    assign core_o_ready = core_o_ready_s;
    assign rsp_crypto   = core_crypto;
    assign owner_id     = owner_id_r;
    assign busy         = (state_r != ARB_IDLE);
    assign last_latency = last_latency_r;

endmodule

// File: tb/tb_rsa_job_arbiter.sv
// Self-checking bench for rsa_job_arbiter: directed vector table, reset cases and
// randomized jobs checked against a round-robin / modular-exponentiation model.
module tb_rsa_job_arbiter;
    import rsa_job_arbiter_pkg::*;

    localparam int N = 4;

    logic                        clk = 1'b0;
    logic                        rst;
    logic [N-1:0]                req_valid, req_ready, rsp_valid, rsp_ready;
    logic [N-1:0][MOD_WIDTH-1:0] req_msg, req_key, req_modulus;
    logic [MOD_WIDTH-1:0]        rsp_crypto, core_msg, core_key, core_modulus, core_crypto;
    logic                        core_i_valid, core_i_ready, core_o_valid, core_o_ready, busy;
    logic [1:0]                  owner_id;
    logic [31:0]                 last_latency;

    int cyc = 0;
    int n_chk = 0;
    int n_pass = 0;
    int ptr_m = 0;

    rsa_job_arbiter #(.N_REQ(N), .ID_W(2), .CNT_W(32)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_msg(req_msg), .req_key(req_key), .req_modulus(req_modulus),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_crypto(rsp_crypto),
        .core_i_valid(core_i_valid), .core_i_ready(core_i_ready),
        .core_msg(core_msg), .core_key(core_key), .core_modulus(core_modulus),
        .core_o_valid(core_o_valid), .core_o_ready(core_o_ready), .core_crypto(core_crypto),
        .owner_id(owner_id), .busy(busy), .last_latency(last_latency)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [3:0] rv;
        int         idx;
        KeyType     m, k, n, c;
        int         in_dly, out_dly, stall;
    } vec_t;

    vec_t tbl[11];

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    function automatic KeyType modexp(input KeyType m, input KeyType e, input KeyType n);
        logic [63:0] r, b, nn;
        nn = 64'(n);
        r  = 64'd1 % nn;
        b  = 64'(m) % nn;
        for (int i = 0; i < MOD_WIDTH; i++) begin
            if (e[i]) r = (r * b) % nn;
            b = (b * b) % nn;
        end
        return r[MOD_WIDTH-1:0];
    endfunction

    function automatic int model_pick(input logic [3:0] rv);
        for (int k = 0; k < N; k++) if (rv[(ptr_m + k) % N]) return (ptr_m + k) % N;
        return -1;
    endfunction

    // One complete job; entered and left at #1 after a rising edge with the DUT idle.
    task automatic do_job(input string tag, input logic [3:0] rv, input int exp_idx, input KeyType exp_c,
                          input int in_dly, input int out_dly, input int stall);
        logic [3:0] own, rest;
        KeyType     em, ek, en;
        int         t_issue, t_done, nxt;
        own  = 4'b0001 << exp_idx;
        rest = rv & ~own;
        em = req_msg[exp_idx]; ek = req_key[exp_idx]; en = req_modulus[exp_idx];
        req_valid = rv;
        #1;
        check({tag, " grant"}, 128'(req_ready), 128'(own));
        @(posedge clk); #1;
        req_valid = rest;
        check({tag, " issue_valid"}, 128'(core_i_valid), 128'(1'b1));
        check({tag, " owner"}, 128'(owner_id), 128'(exp_idx));
        check({tag, " busy"}, 128'(busy), 128'(1'b1));
        check({tag, " payload"}, 128'({core_msg, core_key, core_modulus}), 128'({em, ek, en}));
        for (int i = 0; i < in_dly; i++) begin
            @(posedge clk); #1;
            check({tag, " issue_hold"}, 128'({core_i_valid, req_ready, core_msg, core_key, core_modulus}),
                  128'({1'b1, 4'b0000, em, ek, en}));
        end
        core_i_ready = 1'b1;
        @(posedge clk); #1;
        core_i_ready = 1'b0;
        t_issue = cyc;
        check({tag, " issue_drop"}, 128'(core_i_valid), 128'(1'b0));
        for (int i = 0; i < out_dly; i++) begin
            check({tag, " wait_quiet"}, 128'({rsp_valid, req_ready, core_o_ready}), 128'(9'd0));
            @(posedge clk); #1;
        end
        core_o_valid = 1'b1;
        core_crypto  = modexp(em, ek, en);
        for (int i = 0; i < stall; i++) begin
            rsp_ready = ~own;
            #1;
            check({tag, " stall"}, 128'({core_o_ready, rsp_valid, req_ready, rsp_crypto}),
                  128'({1'b0, own, 4'b0000, exp_c}));
            @(posedge clk); #1;
        end
        rsp_ready = own;
        #1;
        check({tag, " result"}, 128'({core_o_ready, rsp_valid, req_ready, rsp_crypto}),
              128'({1'b1, own, 4'b0000, exp_c}));
        @(posedge clk); #1;
        t_done = cyc;
        core_o_valid = 1'b0;
        rsp_ready    = 4'b0000;
        ptr_m        = (exp_idx + 1) % N;
        check({tag, " idle"}, 128'({busy, rsp_valid}), 128'(5'd0));
        check({tag, " latency"}, 128'(last_latency), 128'(t_done - t_issue));
        nxt = model_pick(rest);
        if (nxt >= 0) check({tag, " next_grant"}, 128'(req_ready), 128'(4'b0001 << nxt));
        req_valid = 4'b0000;
    endtask

    task automatic set_all(input KeyType m, input KeyType k, input KeyType n);
        for (int i = 0; i < N; i++) begin
            req_msg[i] = m; req_key[i] = k; req_modulus[i] = n;
        end
    endtask

    initial begin
        logic [3:0] rv;
        int         w;
        tbl[0]  = '{4'b1111, 0, 32'd2, 32'd10, 32'd1000003, 32'd1024, 0, 1, 0};
        tbl[1]  = '{4'b1111, 1, 32'd2, 32'd10, 32'd1000003, 32'd1024, 1, 0, 1};
        tbl[2]  = '{4'b1111, 2, 32'd2, 32'd10, 32'd1000003, 32'd1024, 0, 2, 0};
        tbl[3]  = '{4'b1111, 3, 32'd2, 32'd10, 32'd1000003, 32'd1024, 2, 0, 2};
        tbl[4]  = '{4'b0001, 0, 32'd3, 32'd5, 32'd7, 32'd5, 0, 0, 0};
        tbl[5]  = '{4'b0100, 2, 32'd3, 32'd5, 32'd7, 32'd5, 0, 1, 0};
        tbl[6]  = '{4'b0101, 0, 32'd3, 32'd4, 32'd1000, 32'd81, 0, 0, 1};
        tbl[7]  = '{4'b1111, 1, 32'd3, 32'd4, 32'd1000, 32'd81, 1, 1, 0};
        tbl[8]  = '{4'b1010, 3, 32'd3, 32'd4, 32'd1000, 32'd81, 0, 3, 20};
        tbl[9]  = '{4'b0110, 1, 32'd5, 32'd3, 32'd13, 32'd8, 5, 0, 0};
        tbl[10] = '{4'b1001, 3, 32'd2, 32'd10, 32'd1000003, 32'd1024, 0, 0, 0};

        rst = 1'b0;
        req_valid = 4'b0000; rsp_ready = 4'b0000;
        core_i_ready = 1'b0; core_o_valid = 1'b0; core_crypto = 32'd0;
        set_all(32'd0, 32'd0, 32'd1);
        #12;
        check("reset_outputs", 128'({busy, core_i_valid, rsp_valid, core_o_ready, owner_id, last_latency, core_msg}),
              128'(0));
        req_valid = 4'b1111;
        #1;
        check("reset_grant", 128'(req_ready), 128'(4'b0001));
        req_valid = 4'b0000;
        @(negedge clk); rst = 1'b1;
        @(posedge clk); #1;

        for (int v = 0; v < 11; v++) begin
            set_all(tbl[v].m, tbl[v].k, tbl[v].n);
            do_job($sformatf("vec%0d", v), tbl[v].rv, tbl[v].idx, tbl[v].c,
                   tbl[v].in_dly, tbl[v].out_dly, tbl[v].stall);
        end

        // Asynchronous reset while a result is pending in WAIT
        set_all(32'd9, 32'd9, 32'd97);
        req_valid = 4'b0010;
        @(posedge clk); #1;
        req_valid = 4'b0000;
        core_i_ready = 1'b1;
        @(posedge clk); #1;
        core_i_ready = 1'b0;
        core_o_valid = 1'b1;
        @(posedge clk); #1;
        check("mid_wait_busy", 128'({busy, rsp_valid}), 128'({1'b1, 4'b0010}));
        #2 rst = 1'b0;
        #1;
        check("async_reset", 128'({busy, core_i_valid, rsp_valid, core_o_ready, owner_id, last_latency, core_msg}),
              128'(0));
        core_o_valid = 1'b0;
        @(negedge clk); rst = 1'b1;
        @(posedge clk); #1;
        ptr_m = 0;
        set_all(32'd3, 32'd5, 32'd7);
        do_job("post_reset", 4'b1111, 0, 32'd5, 0, 0, 0);

        // Randomized jobs with distinct payloads per requester
        for (int j = 0; j < 40; j++) begin
            for (int i = 0; i < N; i++) begin
                req_modulus[i] = 32'($urandom_range(2, 65535));
                req_msg[i]     = 32'($urandom) % req_modulus[i];
                req_key[i]     = 32'($urandom_range(0, 65535));
            end
            rv = 4'($urandom_range(1, 15));
            w  = model_pick(rv);
            do_job($sformatf("rnd%0d", j), rv, w, modexp(req_msg[w], req_key[w], req_modulus[w]),
                   $urandom_range(0, 3), $urandom_range(0, 4), $urandom_range(0, 3));
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
